mem_cmd_master: RTL and testbench
=================================

# mem_cmd_master

Command-issuing master sitting directly upstream of the memory model in the memory testbench top. It accepts read/write commands from a host over a valid/ready channel and buffers them in a small FIFO. It issues each command as a single-cycle access on the memory's `wr`/`addr`/`wdata` pins, then captures `rdata`/`response` and returns a response beat over a second valid/ready channel. Only one command is outstanding at the memory at any time.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: command/memory address width.
- `DATA_WIDTH`, default 32: data width.
- `MEM_SIZE`, default 16: memory depth. Informational; passed through to the package constant, no local range check.
- `CMD_DEPTH`, default 4: command FIFO entries. Power of two, ≥2.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  host command valid.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_wr`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_WIDTH  target address.
- `cmd_wdata`  in  DATA_WIDTH  write data (ignored for reads).
- `rsp_valid`  out  1  response beat valid.
- `rsp_ready`  in  1  host accepts response.
- `rsp_wr`  out  1  echo of command type.
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes.
- `rsp_err`  out  1  captured memory `response` (1 = error).
- `mem_wr`  out  1  to memory `wr`.
- `mem_addr`  out  ADDR_WIDTH  to memory `addr`.
- `mem_wdata`  out  DATA_WIDTH  to memory `wdata`.
- `mem_rdata`  in  DATA_WIDTH  from memory `rdata`.
- `mem_rsp`  in  1  from memory `response`.
- `cmd_count`  out  $clog2(CMD_DEPTH)+1  FIFO occupancy.

## Operation
- Command push occurs when `cmd_valid && cmd_ready`. `cmd_ready = (cmd_count != CMD_DEPTH)`. There is no bypass: a command pushed into an empty FIFO is popped no earlier than the next edge.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
  - IDLE: if FIFO non-empty, pop the head into the issue register and go to ISSUE.
  - ISSUE (1 cycle): `mem_addr`/`mem_wdata` driven from the issue register. `mem_wr` = command's wr bit for this cycle only. Go to CAPTURE.
  - CAPTURE (1 cycle): `mem_wr` = 0 and address held. At the closing edge, latch `rsp_rdata` (`mem_rdata` for reads, 0 for writes), `rsp_err` = `mem_rsp`, and `rsp_wr`. Go to RESP.
  - RESP: `rsp_valid` = 1 and response registers stable. On `rsp_ready`: if FIFO non-empty, pop and go to ISSUE; otherwise go to IDLE. Without `rsp_ready`, stay in RESP; the FIFO keeps accepting pushes.
- `mem_wr` is 0 in every state except ISSUE, so the memory never sees a write outside ISSUE.
- Push and pop in the same cycle are legal at any occupancy below full; `cmd_count` is unchanged. When full, no push is accepted, and a pop in that cycle brings `cmd_ready` high the following cycle.
- FIFO pointers wrap modulo CMD_DEPTH. Occupancy is tracked by an explicit counter.

## Timing
- Reset asserted (`reset` = 0):
  - FSM goes to IDLE and the FIFO is emptied.
  - Outputs: `cmd_ready` = 1, `rsp_valid` = 0, `rsp_wr` = 0, `rsp_rdata` = 0, `rsp_err` = 0, `mem_wr` = 0, `mem_addr` = 0, `mem_wdata` = 0, `cmd_count` = 0.
- Reset mid-operation: any in-flight or queued command is dropped with no response.
- Latency: command accepted at edge E0; pop at E1 (ISSUE E1–E2); CAPTURE E2–E3; `rsp_valid` high after E3. That is 3 cycles, accept to response.
- Throughput with `rsp_ready` held high and FIFO non-empty: one command every 3 cycles.
- `rsp_*` must not change while `rsp_valid` && !`rsp_ready`.

## Structure
- Package `mem_cmd_pkg`:
  - `state_e` enum (IDLE, ISSUE, CAPTURE, RESP).
  - `cmd_t` packed struct {wr, addr, wdata}, parameterised via package localparams matching the top's ADDR_WIDTH=8, DATA_WIDTH=32, MEM_SIZE=16.
- Sub-module `mem_cmd_fifo`: synchronous FIFO of `cmd_t` with push/pop/full/empty/count and async active-low reset. The FSM and issue/response registers live in `mem_cmd_master`.

## Test plan
- Write then read: write addr 0x03 data 0xDEADBEEF, then read 0x03, `rsp_ready` = 1 → write response {wr=1, rdata=0, err=0}, then read response {wr=0, rdata=0xDEADBEEF, err=0}. Each `rsp_valid` appears 3 cycles after its accept.
- Fill FIFO: `rsp_ready` = 0, push 5 reads back-to-back → 1 issued, 4 queued, `cmd_ready` low once `cmd_count` = 4. Release `rsp_ready` → 5 responses in order, `mem_wr` never asserted.
- Out-of-range read: read addr 0x20 while memory drives `response` = 1 → `rsp_err` = 1, response delivered normally.
- Backpressure: hold `rsp_ready` = 0 for 10 cycles during RESP → `rsp_*` stable, no new ISSUE, `mem_wr` = 0 throughout.
- Reset mid-operation: pull `reset` low during CAPTURE with 2 queued → all outputs at reset values, `cmd_count` = 0, no response after release.
- Simultaneous push/pop: at `cmd_count` = 2, push on the same cycle as a RESP→ISSUE pop → `cmd_count` stays 2 and ordering is preserved.

Source files
------------

// File: rtl/mem_cmd_pkg.sv
// Shared types and constants for the memory command master and its FIFO.
package mem_cmd_pkg;

   // Widths the command record is built from; the top checks its own
   // parameters against these at elaboration.
   localparam int PKG_ADDR_W   = 8;
   localparam int PKG_DATA_W   = 32;
   localparam int PKG_MEM_SIZE = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_e;

   typedef struct packed {
      logic                  wr;
      logic [PKG_ADDR_W-1:0] addr;
      logic [PKG_DATA_W-1:0] wdata;
   } cmd_t;

   // Writes return zero read data; reads return what the memory drove.
   function automatic logic [PKG_DATA_W-1:0] rsp_data_sel(
      input logic                  wr,
      input logic [PKG_DATA_W-1:0] rdata
   );
      return wr ? '0 : rdata;
   endfunction

endpackage

// File: rtl/mem_cmd_fifo.sv
// Synchronous command FIFO: power-of-two depth, wrapping pointers and an
// explicit occupancy counter. Push is refused when full, pop when empty.
module mem_cmd_fifo
   import mem_cmd_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  cmd_t             i_push_cmd,
   input  logic             i_pop,
   output cmd_t             o_head,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   localparam int PTR_W = $clog2(DEPTH);

   cmd_t             r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !o_empty;
   assign o_head    = r_mem[r_rd_ptr];
   assign o_count   = r_count;

   // Storage write; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_push_cmd;
      end
   end

   // Pointer and occupancy update; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/mem_cmd_master.sv
// Command master: queues host read/write commands, issues them one at a
// time as a single-cycle memory access, captures the memory's answer and
// returns it on the response channel. One access outstanding at a time.
module mem_cmd_master
   import mem_cmd_pkg::*;
#(
   parameter  int ADDR_WIDTH = 8,
   parameter  int DATA_WIDTH = 32,
   parameter  int MEM_SIZE   = 16,
   parameter  int CMD_DEPTH  = 4,
   localparam int CNT_W      = $clog2(CMD_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_wr,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_wr,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  mem_wr,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_rsp,
   output logic [CNT_W-1:0]      cmd_count
);

   // The queued command record has fixed package widths, so the top-level
   // parameters must agree with them; the FIFO also needs a power-of-two depth.
   if (ADDR_WIDTH != PKG_ADDR_W || DATA_WIDTH != PKG_DATA_W ||
       MEM_SIZE != PKG_MEM_SIZE || CMD_DEPTH < 2 ||
       (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_param_check
      $error("mem_cmd_master: parameters inconsistent with mem_cmd_pkg or CMD_DEPTH not a power of two >= 2");
   end

   state_e                r_state;
   state_e                w_next_state;
   cmd_t                  r_issue;
   cmd_t                  w_push_cmd;
   cmd_t                  w_head;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_pop;
   logic                  w_rsp_valid;
   logic                  w_mem_wr;
   logic                  r_rsp_wr;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_rsp_err;

   assign w_push_cmd.wr    = cmd_wr;
   assign w_push_cmd.addr  = cmd_addr;
   assign w_push_cmd.wdata = cmd_wdata;

   mem_cmd_fifo #(
      .DEPTH      (CMD_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_push     (cmd_valid),
      .i_push_cmd (w_push_cmd),
      .i_pop      (w_pop),
      .o_head     (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_count    (cmd_count)
   );

   assign cmd_ready = !w_full;

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state, FIFO pop and strobe decode. A pop only happens from IDLE or
   // when the current response is being accepted, so one command is in flight.
   always_comb begin
      w_next_state = r_state;
      w_pop        = 1'b0;
      w_rsp_valid  = 1'b0;
      w_mem_wr     = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_next_state = ISSUE;
            end
         end
         ISSUE: begin
            w_mem_wr     = r_issue.wr;
            w_next_state = CAPTURE;
         end
         CAPTURE: begin
            w_next_state = RESP;
         end
         RESP: begin
            w_rsp_valid = 1'b1;
            if (rsp_ready) begin
               if (!w_empty) begin
                  w_pop        = 1'b1;
                  w_next_state = ISSUE;
               end else begin
                  w_next_state = IDLE;
               end
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Issue register: loaded from the FIFO head on pop, held for ISSUE and
   // CAPTURE so the memory address stays stable across both cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_issue <= '0;
      end else if (w_pop) begin
         r_issue <= w_head;
      end
   end

   // Response capture at the end of CAPTURE; untouched while RESP waits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rsp_wr    <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else if (r_state == CAPTURE) begin
         r_rsp_wr    <= r_issue.wr;
         r_rsp_rdata <= rsp_data_sel(r_issue.wr, mem_rdata);
         r_rsp_err   <= mem_rsp;
      end
   end

   assign rsp_valid = w_rsp_valid;
   assign rsp_wr    = r_rsp_wr;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign mem_wr    = w_mem_wr;
   assign mem_addr  = r_issue.addr;
   assign mem_wdata = r_issue.wdata;

endmodule

// File: tb/tb_mem_cmd_master.sv
// Testbench for mem_cmd_master with a behavioural memory and response model.
module tb_mem_cmd_master;

   localparam int AW    = 8;
   localparam int DW    = 32;
   localparam int MSZ   = 16;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic          clk       = 1'b0;
   logic          reset     = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_wr    = 1'b0;
   logic [AW-1:0] cmd_addr  = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          rsp_ready = 1'b0;
   logic          cmd_ready;
   logic          rsp_valid;
   logic          rsp_wr;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_rsp;
   logic [CW-1:0] cmd_count;

   int checks = 0;
   int errors = 0;
   int mem_wr_cycles = 0;

   typedef struct packed {
      logic          wr;
      logic [DW-1:0] rdata;
      logic          err;
   } rsp_exp_t;

   rsp_exp_t      exp_q[$];
   logic [DW-1:0] mem_model [MSZ];
   logic [DW-1:0] shadow    [MSZ];

   mem_cmd_master #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MEM_SIZE   (MSZ),
      .CMD_DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_wr    (cmd_wr),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_wr    (rsp_wr),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_rsp   (mem_rsp),
      .cmd_count (cmd_count)
   );

   always #5 clk = ~clk;

   // Memory model: MSZ words, write on clock edge, combinational read,
   // error response for any address outside the array.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MSZ; i++) mem_model[i] <= '0;
      end else if (mem_wr && (mem_addr < AW'(MSZ))) begin
         mem_model[mem_addr[3:0]] <= mem_wdata;
      end
   end
   assign mem_rdata = (mem_addr < AW'(MSZ)) ? mem_model[mem_addr[3:0]] : '0;
   assign mem_rsp   = (mem_addr >= AW'(MSZ));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one command and hold it until the edge that accepts it.
   task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_wr    = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      while (!cmd_ready && n < 50) begin
         tick();
         n++;
      end
      if (!cmd_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: cmd_ready stayed 0 for %0d cycles, required 1", n);
      end
      tick();
      cmd_valid = 1'b0;
   endtask

   // Count edges from the accept edge until rsp_valid is seen.
   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic drain(input string tag);
      int n = 0;
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      while ((exp_q.size() != 0 || rsp_valid || cmd_count != 0) && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || rsp_valid) begin
         errors++;
         $display("FAIL %s_drain: %0d responses outstanding, required 0", tag, exp_q.size());
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_wr"},    rsp_wr,    0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
      chk({tag, "_rsp_err"},   rsp_err,   0);
      chk({tag, "_mem_wr"},    mem_wr,    0);
      chk({tag, "_mem_addr"},  mem_addr,  0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_cmd_count"}, cmd_count, 0);
   endtask

   // Monitor: predicts each response when its command is accepted, from an
   // in-order shadow of memory, and checks responses and hold behaviour.
   initial begin : monitor
      rsp_exp_t      e;
      logic          prev_hold;
      logic          prev_mem_wr;
      logic [DW+1:0] prev_rsp;
      prev_hold   = 1'b0;
      prev_mem_wr = 1'b0;
      prev_rsp    = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            exp_q.delete();
            for (int i = 0; i < MSZ; i++) shadow[i] = '0;
            prev_hold   = 1'b0;
            prev_mem_wr = 1'b0;
         end else begin
            if (mem_wr) begin
               mem_wr_cycles++;
               chk("mem_wr_single_cycle", prev_mem_wr, 0);
            end
            prev_mem_wr = mem_wr;
            if (prev_hold) begin
               chk("rsp_hold_valid", rsp_valid, 1);
               chk("rsp_hold_data", {rsp_wr, rsp_err, rsp_rdata}, prev_rsp);
            end
            if (rsp_valid && rsp_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL rsp_unexpected: response wr=%0b rdata=0x%0h with none outstanding", rsp_wr, rsp_rdata);
               end else begin
                  e = exp_q.pop_front();
                  chk("model_rsp_wr",    rsp_wr,    e.wr);
                  chk("model_rsp_rdata", rsp_rdata, e.rdata);
                  chk("model_rsp_err",   rsp_err,   e.err);
               end
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_rsp  = {rsp_wr, rsp_err, rsp_rdata};
            chk("cmd_ready_vs_count", cmd_ready, cmd_count != CW'(DEPTH));
            if (cmd_valid && cmd_ready) begin
               e.wr    = cmd_wr;
               e.err   = (cmd_addr >= AW'(MSZ));
               e.rdata = '0;
               if (!cmd_wr && !e.err) e.rdata = shadow[cmd_addr[3:0]];
               if (cmd_wr && !e.err) shadow[cmd_addr[3:0]] = cmd_wdata;
               exp_q.push_back(e);
            end
         end
      end
   end

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          exp_wr;
      logic [DW-1:0] exp_rdata;
      logic          exp_err;
   } vec_t;

   initial begin : stimulus
      vec_t          vecs [10];
      int            lat;
      int            wc0;
      logic [DW+1:0] held_rsp;
      logic [AW-1:0] held_addr;

      vecs[0] = '{1'b1, 8'h03, 32'hDEADBEEF, 1'b1, 32'h0,        1'b0};
      vecs[1] = '{1'b0, 8'h03, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
      vecs[2] = '{1'b0, 8'h20, 32'h0,        1'b0, 32'h0,        1'b1};
      vecs[3] = '{1'b1, 8'h0F, 32'h12345678, 1'b1, 32'h0,        1'b0};
      vecs[4] = '{1'b0, 8'h0F, 32'h0,        1'b0, 32'h12345678, 1'b0};
      vecs[5] = '{1'b1, 8'h10, 32'hCAFEF00D, 1'b1, 32'h0,        1'b1};
      vecs[6] = '{1'b0, 8'h10, 32'h0,        1'b0, 32'h0,        1'b1};
      vecs[7] = '{1'b0, 8'h00, 32'h0,        1'b0, 32'h0,        1'b0};
      vecs[8] = '{1'b1, 8'h03, 32'hA5A5A5A5, 1'b1, 32'h0,        1'b0};
      vecs[9] = '{1'b0, 8'h03, 32'h0,        1'b0, 32'hA5A5A5A5, 1'b0};

      // Reset values
      tick();
      tick();
      check_reset_outputs("reset");
      reset = 1'b1;
      tick();

      // Table: one command at a time, response accepted immediately
      rsp_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wc0 = mem_wr_cycles;
         send(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
         wait_rsp(lat);
         chk($sformatf("vec%0d_latency", i),   lat,       3);
         chk($sformatf("vec%0d_rsp_wr", i),    rsp_wr,    vecs[i].exp_wr);
         chk($sformatf("vec%0d_rsp_rdata", i), rsp_rdata, vecs[i].exp_rdata);
         chk($sformatf("vec%0d_rsp_err", i),   rsp_err,   vecs[i].exp_err);
         tick();
         chk($sformatf("vec%0d_mem_wr_pulses", i), mem_wr_cycles - wc0, vecs[i].wr);
      end

      // Fill the FIFO behind a stalled response
      rsp_ready = 1'b0;
      wc0 = mem_wr_cycles;
      for (int i = 0; i < 5; i++) send(1'b0, AW'(i), $urandom);
      chk("fill_count",     cmd_count, 4);
      chk("fill_cmd_ready", cmd_ready, 0);
      tick();
      tick();
      chk("fill_count_held",     cmd_count, 4);
      chk("fill_cmd_ready_held", cmd_ready, 0);
      rsp_ready = 1'b1;
      chk("fill_release_ready_before_edge", cmd_ready, 0);
      tick();
      chk("fill_release_ready_after_pop", cmd_ready, 1);
      chk("fill_release_count",           cmd_count, 3);
      drain("fill");
      chk("fill_no_mem_wr", mem_wr_cycles - wc0, 0);

      // Backpressure for 10 cycles with a further command waiting
      rsp_ready = 1'b0;
      send(1'b0, 8'h03, 32'h0);
      wait_rsp(lat);
      chk("bp_latency", lat, 3);
      chk("bp_rdata",   rsp_rdata, 32'hA5A5A5A5);
      held_rsp  = {rsp_wr, rsp_err, rsp_rdata};
      held_addr = mem_addr;
      send(1'b1, 8'h05, 32'h11111111);
      for (int i = 0; i < 10; i++) begin
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_data",  {rsp_wr, rsp_err, rsp_rdata}, held_rsp);
         chk("bp_mem_wr",    mem_wr, 0);
         chk("bp_mem_addr",  mem_addr, held_addr);
         chk("bp_count",     cmd_count, 1);
         tick();
      end
      drain("bp");

      // Push and pop on the same edge at occupancy 2
      rsp_ready = 1'b0;
      send(1'b1, 8'h07, 32'h77777777);
      send(1'b0, 8'h07, 32'h0);
      send(1'b1, 8'h08, 32'h88888888);
      wait_rsp(lat);
      chk("pp_first_rsp_wr", rsp_wr, 1);
      chk("pp_count_before", cmd_count, 2);
      rsp_ready = 1'b1;
      send(1'b0, 8'h08, 32'h0);
      chk("pp_count_after", cmd_count, 2);
      chk("pp_rsp_valid_after", rsp_valid, 0);
      drain("pp");

      // Reset during CAPTURE with two commands queued
      rsp_ready = 1'b1;
      send(1'b0, 8'h03, 32'h0);
      send(1'b0, 8'h0F, 32'h0);
      send(1'b0, 8'h00, 32'h0);
      chk("rst_mid_count_before", cmd_count, 2);
      reset = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      tick();
      tick();
      reset = 1'b1;
      wc0 = mem_wr_cycles;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("rst_mid_no_rsp", rsp_valid, 0);
      end
      chk("rst_mid_count_after", cmd_count, 0);
      chk("rst_mid_no_issue", mem_wr_cycles - wc0, 0);

      // Randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_wr    = 1'($urandom_range(0, 1));
         cmd_addr  = AW'($urandom_range(0, 19));
         cmd_wdata = $urandom;
         rsp_ready = ($urandom_range(0, 9) < 7);
         tick();
      end
      drain("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
